asym_fifo_read_wider: RTL and testbench

Single-clock FIFO with a narrow write stream and a wide read stream. It is the read-wider counterpart of the write-wider asymmetric RAM. Narrow words enter through a valid/ready port and are packed into a shared RAM; the first narrow word accepted fills the least significant slice. Whole wide words leave through a valid/ready port. It sits between narrow producers (readback and capture paths) and wide consumers (host DMA / AXI packer) in the zcu216 top.

---
 rtl/asym_fifo_read_wider.sv | 154 +++++++++++++++
 tb/tb_asym_fifo_read_wider.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/asym_fifo_read_wider.sv
// asym_fifo_read_wider
// Single-clock asymmetric FIFO: narrow words in, wide words out.
// Narrow words are packed into a shared RAM. The first narrow word of each
// group lands in the least significant slice. Complete wide words are read
// through a one-entry output register.
//
// Optional feature macro: ASYM_FIFO_FLUSH_EN
//   When defined, a flush pulse pads the pending partial wide word with zero
//   slices (PAD state) so that it becomes readable. When undefined, flush is
//   ignored, flush_busy is tied low, and a partial word stays invisible until
//   enough narrow words arrive.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | normal operation, narrow writes accepted
// PAD   | writing one zero slice per cycle up to the next wide boundary
module asym_fifo_read_wider #(
  parameter int DATAWIDTHA = 4,
  parameter int DATAWIDTHB = 16,
  parameter int SIZEA      = 1024,
  parameter int ADDRWIDTHA = 10,
  parameter int SIZEB      = 256,
  parameter int ADDRWIDTHB = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATAWIDTHA-1:0] wr_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATAWIDTHB-1:0] rd_data,
  input  logic                  flush,
  output logic                  flush_busy,
  output logic [ADDRWIDTHA:0]   level
);

  localparam int RATIO = DATAWIDTHB / DATAWIDTHA;
  localparam int LOG2R = $clog2(RATIO);

  localparam logic [ADDRWIDTHA:0] RATIO_W = (ADDRWIDTHA + 1)'(RATIO);
  localparam logic [ADDRWIDTHA:0] SIZEA_W = (ADDRWIDTHA + 1)'(SIZEA);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_PAD  = 1'b1;

  // Shared RAM, organised as wide words of RATIO narrow slices.
  logic [RATIO-1:0][DATAWIDTHA-1:0] mem [SIZEB];

  logic [ADDRWIDTHA:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDRWIDTHB:0]   rd_ptr_q, rd_ptr_d;
  logic [0:0]            state_q, state_d;
  logic                  inflight_q, inflight_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATAWIDTHB-1:0] rd_data_q, rd_data_d;
  logic [DATAWIDTHB-1:0] ram_rd_q;

  logic                  wr_fire;
  logic                  pad_fire;
  logic                  ram_we;
  logic [DATAWIDTHA-1:0] ram_wdata;
  logic                  avail;
  logic                  pop;
  logic                  issue;

  // Occupancy, handshakes and read-issue decision.
  always_comb begin
    level     = wr_ptr_q - {rd_ptr_q, {LOG2R{1'b0}}};
    wr_ready  = !rst && (level != SIZEA_W) && (state_q == ST_IDLE);
    wr_fire   = wr_valid && wr_ready;
    pad_fire  = (state_q == ST_PAD);
    ram_we    = wr_fire || pad_fire;
    ram_wdata = pad_fire ? '0 : wr_data;
    avail     = (level >= RATIO_W);
    pop       = out_valid_q && rd_ready;
    // Only one read may be in flight, and its landing slot in the output
    // register must be free by the time the data arrives.
    issue     = avail && !inflight_q && (!out_valid_q || pop);
  end

  // Pointer and output-register next state.
  always_comb begin
    wr_ptr_d   = wr_ptr_q + {{ADDRWIDTHA{1'b0}}, ram_we};
    rd_ptr_d   = rd_ptr_q + {{ADDRWIDTHB{1'b0}}, issue};
    inflight_d = issue;
    if (inflight_q) begin
      out_valid_d = 1'b1;
    end else if (pop) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
    rd_data_d = inflight_q ? ram_rd_q : rd_data_q;
  end

`ifdef ASYM_FIFO_FLUSH_EN
  // Flush sequencing; alignment is judged on the post-write pointer so a
  // write in the same cycle as flush counts toward the group.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (flush && (wr_ptr_d[LOG2R-1:0] != '0)) state_d = ST_PAD;
      ST_PAD:  if (wr_ptr_d[LOG2R-1:0] == '0) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign flush_busy = (state_q == ST_PAD);
`else
  logic unused_flush;
  assign unused_flush = flush;

  // Without flush support the controller never leaves IDLE.
  always_comb begin
    state_d = ST_IDLE;
  end

  assign flush_busy = 1'b0;
`endif

  // Control registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      state_q     <= ST_IDLE;
      inflight_q  <= 1'b0;
      out_valid_q <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      state_q     <= state_d;
      inflight_q  <= inflight_d;
      out_valid_q <= out_valid_d;
      rd_data_q   <= rd_data_d;
    end
  end

  // RAM: narrow slice write, wide synchronous read. No reset, so it can map
  // onto a block RAM; stale read data is never forwarded without an issue.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem[wr_ptr_q[ADDRWIDTHA-1:LOG2R]][wr_ptr_q[LOG2R-1:0]] <= ram_wdata;
    end
    if (issue) begin
      ram_rd_q <= mem[rd_ptr_q[ADDRWIDTHB-1:0]];
    end
  end

  assign rd_valid = out_valid_q;
  assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_asym_fifo_read_wider.sv
// Bench for asym_fifo_read_wider: queue-based reference model, per-cycle
// compare process, directed literal checks and randomized traffic.
module tb_asym_fifo_read_wider;

  localparam int DWA = 4;
  localparam int DWB = 16;
  localparam int SA  = 1024;
  localparam int R   = DWB / DWA;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [DWA-1:0] wr_data = '0;
  logic          rd_valid;
  logic          rd_ready = 1'b0;
  logic [DWB-1:0] rd_data;
  logic          flush = 1'b0;
  logic          flush_busy;
  logic [10:0]   level;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  asym_fifo_read_wider #(
    .DATAWIDTHA(4), .DATAWIDTHB(16), .SIZEA(1024),
    .ADDRWIDTHA(10), .SIZEB(256), .ADDRWIDTHB(8)
  ) dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .flush(flush), .flush_busy(flush_busy), .level(level)
  );

  always #5 clk = ~clk;

  // Reference model: narrow words held in RAM, pad slots owed, one wide word
  // in flight from RAM, and the output register.
  logic [DWA-1:0] nq[$];
  int             m_total;
  int             m_pad;
  bit             m_pend;
  logic [DWB-1:0] m_pend_data;
  bit             m_ov;
  logic [DWB-1:0] m_od;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic fail_timeout(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: bound expired at %0t", nm, $time);
  endtask

  initial begin : model
    bit wf, pd, pop, iss;
    logic [DWB-1:0] w;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        nq.delete();
        m_total = 0; m_pad = 0; m_pend = 1'b0; m_pend_data = '0;
        m_ov = 1'b0; m_od = '0;
      end else begin
        wf  = wr_valid && (nq.size() != SA) && (m_pad == 0);
        pd  = (m_pad > 0);
        pop = m_ov && rd_ready;
        iss = (nq.size() >= R) && !m_pend && (!m_ov || pop);
        if (m_pend) begin
          m_ov = 1'b1;
          m_od = m_pend_data;
        end else if (pop) begin
          m_ov = 1'b0;
        end
        m_pend = iss;
        if (iss) begin
          w = '0;
          for (int i = 0; i < R; i++) w[i*DWA +: DWA] = nq.pop_front();
          m_pend_data = w;
        end
        if (wf) begin nq.push_back(wr_data); m_total++; end
        if (pd) begin nq.push_back('0); m_total++; m_pad--; end
`ifdef ASYM_FIFO_FLUSH_EN
        if (!pd && flush && (m_total % R) != 0) m_pad = R - (m_total % R);
`endif
      end
    end
  end

  // Compare process: outputs against the model on every falling edge.
  initial begin : compare
    forever begin
      @(negedge clk);
      if (check_en && !rst) begin
        chk("wr_ready", 32'(wr_ready), 32'((nq.size() != SA) && (m_pad == 0)));
        chk("level", 32'(level), 32'(nq.size()));
        chk("flush_busy", 32'(flush_busy), 32'(m_pad > 0));
        chk("rd_valid", 32'(rd_valid), 32'(m_ov));
        if (m_ov) chk("rd_data", 32'(rd_data), 32'(m_od));
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; wr_valid = 1'b0; flush = 1'b0; rd_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic write_word(input logic [DWA-1:0] d, input bit fl);
    wr_valid = 1'b1; wr_data = d; flush = fl;
    tick();
    wr_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    wr_valid = 1'b0; flush = 1'b0; rd_ready = 1'b1;
    while ((nq.size() >= R || m_ov || m_pend || m_pad > 0) && k < 3000) begin
      tick(); k++;
    end
    if (k >= 3000) fail_timeout("drain");
  endtask

  task automatic random_phase(input int cycles, input int wr_pct, input int rd_pct);
    for (int c = 0; c < cycles; c++) begin
      wr_valid = ($urandom_range(0, 99) < wr_pct);
      wr_data  = 4'($urandom_range(0, 15));
      rd_ready = ($urandom_range(0, 99) < rd_pct);
      flush    = ($urandom_range(0, 24) == 0);
      tick();
    end
    wr_valid = 1'b0; flush = 1'b0;
  endtask

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    int k, busy_cnt, seen;
    logic [DWB-1:0] last;

    tick(); tick();
    chk("rst_wr_ready", 32'(wr_ready), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_flush_busy", 32'(flush_busy), 32'd0);
    rst = 1'b0;
    #1;
    chk("wr_ready_after_rst", 32'(wr_ready), 32'd1);
    check_en = 1'b1;

    // Four back-to-back writes, read latency and packing order.
    rd_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      wr_valid = 1'b1; wr_data = 4'(i);
      tick();
    end
    wr_valid = 1'b0;
    tick();
    chk("t1_valid_n1", 32'(rd_valid), 32'd0);
    tick();
    chk("t1_valid_n2", 32'(rd_valid), 32'd1);
    chk("t1_data", 32'(rd_data), 32'h4321);
    tick();
    chk("t1_valid_n3", 32'(rd_valid), 32'd0);

    // Randomized traffic with varied producer/consumer pressure.
    random_phase(1000, 60, 80);
    random_phase(800, 90, 20);
    random_phase(800, 40, 95);

    // Fill to full from an arbitrary pointer offset, pop one, read all back.
    drain();
    rd_ready = 1'b0;
    wr_valid = 1'b1;
    k = 0;
    while (nq.size() != SA && k < 1200) begin
      wr_data = 4'($urandom_range(0, 15));
      tick(); k++;
    end
    if (k >= 1200) fail_timeout("fill");
    chk("full_level", 32'(level), 32'd1024);
    chk("full_wr_ready", 32'(wr_ready), 32'd0);
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    chk("after_pop_level", 32'(level), 32'd1020);
    chk("after_pop_wr_ready", 32'(wr_ready), 32'd1);
    wr_valid = 1'b0;
    drain();

    // Flush of a two-slice partial word.
    do_reset();
    rd_ready = 1'b1;
    write_word(4'hA, 1'b0);
    write_word(4'hB, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    busy_cnt = 0; seen = 0; last = '0;
    for (int j = 0; j < 10; j++) begin
      if (flush_busy) busy_cnt++;
      if (rd_valid) begin seen++; last = rd_data; end
      tick();
    end
`ifdef ASYM_FIFO_FLUSH_EN
    chk("flush_busy_cycles", 32'(busy_cnt), 32'd2);
    chk("flush_word_seen", 32'(seen), 32'd1);
    chk("flush_rd_data", 32'(last), 32'h00BA);
`else
    chk("noflush_busy_cycles", 32'(busy_cnt), 32'd0);
    chk("noflush_word_seen", 32'(seen), 32'd0);
`endif

    // Flush on the write completing a group is a no-op; then hold output.
    do_reset();
    rd_ready = 1'b0;
    write_word(4'h5, 1'b0);
    write_word(4'h6, 1'b0);
    write_word(4'h7, 1'b0);
    write_word(4'h8, 1'b1);
    busy_cnt = 0;
    for (int j = 0; j < 4; j++) begin
      if (flush_busy) busy_cnt++;
      tick();
    end
    chk("aligned_flush_busy", 32'(busy_cnt), 32'd0);
    chk("hold_valid", 32'(rd_valid), 32'd1);
    chk("hold_data0", 32'(rd_data), 32'h8765);
    chk("hold_level0", 32'(level), 32'd0);
    for (int j = 0; j < 8; j++) write_word(4'(j + 1), 1'b0);
    tick();
    chk("hold_data1", 32'(rd_data), 32'h8765);
    chk("hold_level1", 32'(level), 32'd8);

    // Reset during a pad sequence (a partial word and a held output exist).
    write_word(4'h3, 1'b1);
`ifdef ASYM_FIFO_FLUSH_EN
    chk("pad_active", 32'(flush_busy), 32'd1);
`endif
    rst = 1'b1;
    #1;
    chk("midrst_wr_ready", 32'(wr_ready), 32'd0);
    chk("midrst_rd_valid", 32'(rd_valid), 32'd0);
    chk("midrst_rd_data", 32'(rd_data), 32'd0);
    chk("midrst_level", 32'(level), 32'd0);
    chk("midrst_flush_busy", 32'(flush_busy), 32'd0);
    tick();
    rst = 1'b0;

    random_phase(600, 70, 70);
    drain();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
